raster_to_block: RTL

- Converts a raster-order pixel stream (row by row, full frame width) into 8x8 block-order samples for the noise-estimation stage.
- Buffers one strip of BLOCK_SIZE lines, then replays it block by block.
- Outputs per-block sample beats plus start_of_frame, end_of_frame and blocks_per_frame, which the noise-estimation FSM and its shift register consume directly.

---
 rtl/raster_to_block_if.sv | 22 ++
 rtl/raster_to_block.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/raster_to_block_if.sv
// Pixel handshakes for raster_to_block: raster input stream (s_*) and block-order output stream (m_*).
interface raster_to_block_if #(parameter int DATA_WIDTH = 8);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_sof;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  start_of_frame;
  logic                  end_of_frame;

  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_data, start_of_frame, end_of_frame
  );

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_data, start_of_frame, end_of_frame
  );
endinterface

// File: rtl/raster_to_block.sv
// Raster-to-block reorder: fills one strip of BLOCK_SIZE lines, then replays it as
// BLOCK_SIZE x BLOCK_SIZE blocks, left to right, with frame start/end markers.
module raster_to_block #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int MAX_WIDTH  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  output logic [31:0] blocks_per_frame,
  output logic        err_dim,
  raster_to_block_if.slave io
);
  localparam int LB    = $clog2(BLOCK_SIZE);
  localparam int DEPTH = BLOCK_SIZE * MAX_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [15:0]   BS16 = 16'(BLOCK_SIZE);
  localparam logic [15:0]   MW16 = 16'(MAX_WIDTH);
  localparam logic [LB-1:0] LAST = LB'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t              state;
  logic [15:0]         w_px, h_px;
  logic [15:0]         col, strip_count, bx;
  logic [LB-1:0]       row, r, c;
  logic                rd_done;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [15:0]   fw_t, fh_t, wq, hq;
  logic          dim_bad, acc, we, load, sof_pt, eof_pt;
  logic [AW-1:0] wa, rd_addr;

  assign fw_t    = frame_width  & ~(BS16 - 16'd1);
  assign fh_t    = frame_height & ~(BS16 - 16'd1);
  assign dim_bad = (fw_t < BS16) || (fh_t < BS16) || (fw_t > MW16);
  assign wq      = w_px >> LB;
  assign hq      = h_px >> LB;

  assign acc     = io.s_valid && io.s_ready;
  assign we      = acc && (io.s_sof ? !dim_bad : (state == FILL));
  assign wa      = io.s_sof ? '0 : AW'(row) * AW'(MAX_WIDTH) + AW'(col);
  assign rd_addr = AW'(r) * AW'(MAX_WIDTH) + AW'(bx) * AW'(BLOCK_SIZE) + AW'(c);

  // Next output beat is fetched whenever the output register is empty or being consumed.
  assign load    = (state == DRAIN) && !rd_done && (!io.m_valid || io.m_ready);
  assign sof_pt  = (strip_count == 16'd0) && (bx == 16'd0) && (r == '0) && (c == '0);
  assign eof_pt  = (strip_count == hq - 16'd1) && (bx == wq - 16'd1) && (r == LAST) && (c == LAST);

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= io.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      io.s_ready        <= 1'b0;
      io.m_valid        <= 1'b0;
      io.m_data         <= '0;
      io.start_of_frame <= 1'b0;
      io.end_of_frame   <= 1'b0;
      blocks_per_frame  <= '0;
      err_dim           <= 1'b0;
      w_px              <= '0;
      h_px              <= '0;
      col               <= '0;
      row               <= '0;
      strip_count       <= '0;
      bx                <= '0;
      r                 <= '0;
      c                 <= '0;
      rd_done           <= 1'b0;
    end else begin
      err_dim <= 1'b0;
      case (state)
        IDLE, FILL: begin
          io.s_ready <= 1'b1;
          if (acc && io.s_sof) begin
            // A start-of-frame always restarts, even mid-fill; bad dimensions park in IDLE.
            if (dim_bad) begin
              err_dim <= 1'b1;
              state   <= IDLE;
            end else begin
              w_px             <= fw_t;
              h_px             <= fh_t;
              blocks_per_frame <= 32'(fw_t >> LB) * 32'(fh_t >> LB);
              row              <= '0;
              col              <= 16'd1;
              strip_count      <= '0;
              state            <= FILL;
            end
          end else if (acc && state == FILL) begin
            if (col == w_px - 16'd1) begin
              col <= '0;
              row <= row + 1'b1;
              if (row == LAST) begin
                state      <= DRAIN;
                io.s_ready <= 1'b0;
                bx         <= '0;
                r          <= '0;
                c          <= '0;
                rd_done    <= 1'b0;
              end
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (load) begin
            io.m_valid        <= 1'b1;
            io.m_data         <= mem[rd_addr];
            io.start_of_frame <= sof_pt;
            io.end_of_frame   <= eof_pt;
            c <= c + 1'b1;
            if (c == LAST) begin
              r <= r + 1'b1;
              if (r == LAST) begin
                bx <= bx + 16'd1;
                if (bx == wq - 16'd1) rd_done <= 1'b1;
              end
            end
          end else if (io.m_valid && io.m_ready) begin
            // Last beat of the strip consumed: refill the next strip or finish the frame.
            io.m_valid        <= 1'b0;
            io.start_of_frame <= 1'b0;
            io.end_of_frame   <= 1'b0;
            io.s_ready        <= 1'b1;
            if (strip_count < hq - 16'd1) begin
              strip_count <= strip_count + 16'd1;
              row         <= '0;
              col         <= '0;
              state       <= FILL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
